// File: rtl/magphase_phase_diff_pkg.sv
// Shared constants and types for the magnitude/phase differentiator.
package magphase_phase_diff_pkg;

    localparam logic [7:0]  PDIFF_CTRL_ADDR    = 8'd194;
    localparam logic [7:0]  PDIFF_SQUELCH_ADDR = 8'd195;

    localparam int          CTRL_RST_ON_EOP    = 0;
    localparam int          CTRL_CLR_CNT       = 1;

    // Most negative Q1.15 value: no magnitude can be below it, so squelch never fires.
    localparam logic [15:0] SQUELCH_DISABLE    = 16'h8000;

    typedef struct packed {
        logic        last;
        logic [15:0] mag;
        logic [15:0] delta;
    } pdiff_beat_t;

    localparam int BEAT_W = $bits(pdiff_beat_t);

    // Modulo-2^16 difference; +pi/-pi crossings wrap to a small delta.
    function automatic logic [15:0] wrap_delta(input logic [15:0] phase, input logic [15:0] prev);
        return phase - prev;
    endfunction

endpackage

// File: rtl/magphase_phase_diff_pipe_stage.sv
// Generic one-deep registered AXI-stream stage; advances whenever empty or drained.
module pdiff_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             enable;

    assign enable     = !valid_q || out_ready_i;
    assign in_ready_o = enable;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (enable) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/setting_reg.sv
// Single settings-bus register: captures data when the strobe hits its address.
module setting_reg #(
    parameter logic [7:0] ADDR     = 8'd0,
    parameter int         WIDTH    = 32,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_i,
    input  logic [7:0]       addr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= AT_RESET;
        end else if (strobe_i && (addr_i == ADDR)) begin
            out_q <= data_i;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/magphase_phase_diff.sv
// Phase differentiator on a mag/phase stream with magnitude squelch.
// Delta is computed at acceptance, then carried through two registered stages.
module magphase_phase_diff
    import magphase_phase_diff_pkg::*;
#(
    parameter logic [7:0] SR_PDIFF_CTRL    = PDIFF_CTRL_ADDR,
    parameter logic [7:0] SR_PDIFF_SQUELCH = PDIFF_SQUELCH_ADDR
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [31:0] squelch_count
);

    logic        ctrl_wr;
    logic        clr_cnt;
    logic        rst_on_eop;
    logic [15:0] squelch_thr;
    logic        unused_set_data;

    // CLR_CNT and the history clear act on the strobe itself; only RST_ON_EOP is held.
    assign ctrl_wr         = set_stb && (set_addr == SR_PDIFF_CTRL);
    assign clr_cnt         = ctrl_wr && set_data[CTRL_CLR_CNT];
    assign unused_set_data = ^set_data[31:16];

    setting_reg #(.ADDR(SR_PDIFF_CTRL), .WIDTH(1), .AT_RESET(1'b0)) u_ctrl_reg (
        .clk      (ce_clk),
        .rst      (ce_rst),
        .strobe_i (set_stb),
        .addr_i   (set_addr),
        .data_i   (set_data[CTRL_RST_ON_EOP]),
        .out_o    (rst_on_eop)
    );

    setting_reg #(.ADDR(SR_PDIFF_SQUELCH), .WIDTH(16), .AT_RESET(SQUELCH_DISABLE)) u_squelch_reg (
        .clk      (ce_clk),
        .rst      (ce_rst),
        .strobe_i (set_stb),
        .addr_i   (set_addr),
        .data_i   (set_data[15:0]),
        .out_o    (squelch_thr)
    );

    logic        accept;
    logic [15:0] in_mag;
    logic [15:0] in_phase;
    logic        squelch;

    logic [15:0] prev_phase_q, prev_phase_d;
    logic        hist_valid_q, hist_valid_d;
    logic [31:0] squelch_count_q, squelch_count_d;

    pdiff_beat_t beat_in, beat_mid, beat_out;
    logic        mid_valid, mid_ready;

    assign accept   = i_tvalid && i_tready;
    assign in_mag   = i_tdata[31:16];
    assign in_phase = i_tdata[15:0];
    assign squelch  = $signed(in_mag) < $signed(squelch_thr);

    always_comb begin
        beat_in.last  = i_tlast;
        beat_in.mag   = in_mag;
        beat_in.delta = (hist_valid_q && !squelch) ? wrap_delta(in_phase, prev_phase_q) : 16'h0000;
    end

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        prev_phase_d = prev_phase_q;
        hist_valid_d = hist_valid_q;
        if (accept) begin
            prev_phase_d = in_phase;
            hist_valid_d = !(i_tlast && rst_on_eop);
        end
        // A coincident control write wins, so the following sample starts fresh.
        if (ctrl_wr) begin
            hist_valid_d = 1'b0;
        end
    end

    always_comb begin
        squelch_count_d = squelch_count_q;
        if (clr_cnt) begin
            squelch_count_d = '0;
        end else if (accept && squelch && (squelch_count_q != 32'hFFFF_FFFF)) begin
            squelch_count_d = squelch_count_q + 32'd1;
        end
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            prev_phase_q    <= '0;
            hist_valid_q    <= 1'b0;
            squelch_count_q <= '0;
        end else begin
            prev_phase_q    <= prev_phase_d;
            hist_valid_q    <= hist_valid_d;
            squelch_count_q <= squelch_count_d;
        end
    end

    assign squelch_count = squelch_count_q;

    pdiff_pipe_stage #(.WIDTH(BEAT_W)) u_stage0 (
        .clk         (ce_clk),
        .rst         (ce_rst),
        .in_data_i   (beat_in),
        .in_valid_i  (i_tvalid),
        .in_ready_o  (i_tready),
        .out_data_o  (beat_mid),
        .out_valid_o (mid_valid),
        .out_ready_i (mid_ready)
    );

    pdiff_pipe_stage #(.WIDTH(BEAT_W)) u_stage1 (
        .clk         (ce_clk),
        .rst         (ce_rst),
        .in_data_i   (beat_mid),
        .in_valid_i  (mid_valid),
        .in_ready_o  (mid_ready),
        .out_data_o  (beat_out),
        .out_valid_o (o_tvalid),
        .out_ready_i (o_tready)
    );

    assign o_tdata = {beat_out.mag, beat_out.delta};
    assign o_tlast = beat_out.last;

endmodule

// File: doc/magphase_phase_diff.md
MAGPHASE_PHASE_DIFF -- requirements
Module: magphase_phase_diff

Interface
REQ-001 Parameter SR_PDIFF_CTRL, default 194, settings address of the control register.
REQ-002 Parameter SR_PDIFF_SQUELCH, default 195, settings address of the squelch threshold register.
REQ-003 ce_clk  in  1  sole clock; all logic is synchronous to its rising edge.
REQ-004 ce_rst  in  1  asynchronous, active-high reset.
REQ-005 set_stb  in  1  settings write strobe.
REQ-006 set_addr  in  8  settings address.
REQ-007 set_data  in  32  settings write data.
REQ-008 i_tdata  in  32  input sample: [31:16] magnitude (signed Q1.15), [15:0] phase (signed, full scale = +/-pi).
REQ-009 i_tlast, i_tvalid  in  1 each  input packet end and valid.
REQ-010 i_tready  out  1  input ready.
REQ-011 o_tdata  out  32  [31:16] magnitude, passed through unchanged; [15:0] delta-phase.
REQ-012 o_tlast, o_tvalid  out  1 each  output packet end and valid.
REQ-013 o_tready  in  1  output ready.
REQ-014 squelch_count  out  32  number of squelched samples, for readback.

Function
REQ-015 Control register, 2 bits: bit0 = RST_ON_EOP (clears phase history after each tlast); bit1 = CLR_CNT (self-clearing pulse that zeroes squelch_count). Reset value 0.
REQ-016 Squelch register: 16-bit signed threshold in set_data[15:0]. Reset value 0x8000 (squelch disabled).
REQ-017 Datapath: 2-stage pipeline. A sample accepted at cycle N is presented on o_tvalid/o_tdata at cycle N+2 when o_tready is held high.
REQ-018 Throughput: one sample per cycle while o_tready = 1.
REQ-019 Pipeline advance: enable = ~o_tvalid | o_tready; i_tready = enable. No bubbles are inserted and no sample is dropped or duplicated under any backpressure pattern.
REQ-020 Output stability: o_tdata and o_tlast hold stable while o_tvalid = 1 and o_tready = 0.
REQ-021 Delta computation: delta = (phase - prev_phase) mod 2^16, using two's-complement wrap with no saturation, so +pi to -pi crossings yield small deltas.
REQ-022 History: prev_phase updates with the phase of every accepted sample, including squelched samples.
REQ-023 History valid flag:
- cleared by reset;
- cleared by any write to SR_PDIFF_CTRL;
- cleared after an accepted tlast when RST_ON_EOP = 1;
- set by every other accepted sample.
While the flag is clear, delta = 0.
REQ-024 Squelch: if signed magnitude < threshold, delta is forced to 0 and squelch_count increments by 1.
REQ-025 squelch_count saturates at 0xFFFFFFFF.
REQ-026 If CLR_CNT and a squelch event occur in the same cycle, squelch_count becomes 0.
REQ-027 tlast is delayed in lockstep with its sample.
REQ-028 Timing of settings writes: a write takes effect for samples accepted on the cycle after set_stb. Samples already in the pipeline are unaffected.
REQ-029 Simultaneous events: a settings write coincident with a sample acceptance applies to the following sample.

Reset
REQ-030 On ce_rst assertion, asynchronously: o_tvalid = 0, o_tlast = 0, o_tdata = 0, squelch_count = 0, prev_phase = 0, history flag = 0, registers to the reset values in REQ-015 and REQ-016.
REQ-031 i_tready = 1 on the first cycle after reset deasserts.
REQ-032 Reset mid-packet discards all in-flight samples. The first post-reset output has delta = 0.

Structure
REQ-033 A shared package holds SR_PDIFF_CTRL, SR_PDIFF_SQUELCH, control bit indices and the squelch disable value 0x8000.
REQ-034 One sub-module, pdiff_pipe_stage: a generic 1-deep registered AXI-stream stage with the REQ-019 enable rule, instantiated twice.
REQ-035 Settings decode lives in the top level, using setting_reg instances.

Verification
REQ-036 Reset, then phases 0x0000, 0x1000, 0x3000 with o_tready = 1 -> deltas 0x0000, 0x1000, 0x2000; each output appears 2 cycles after acceptance.
REQ-037 Phases 0x7F00 then 0x8100 -> delta 0x0200; phases 0x8100 then 0x7F00 -> delta 0xFE00.
REQ-038 RST_ON_EOP = 1; packet A = 0x0100, 0x0200 (tlast); packet B = 0x0500 -> deltas 0, 0x0100, 0. With RST_ON_EOP = 0, packet B delta = 0x0300.
REQ-039 Threshold 0x0100; magnitudes 0x0080, 0x0200, 0x00FF -> deltas forced 0 on samples 1 and 3; squelch_count = 2; CLR_CNT write -> 0.
REQ-040 Random o_tready (50%) and random i_tvalid over 10,000 samples -> output sequence matches the reference model exactly, with tlast positions preserved.
REQ-041 Assert ce_rst with 2 samples in flight -> o_tvalid = 0 immediately (asynchronous); the next output carries delta = 0.
